// File: rtl/id_operand_stage.sv
// id_operand_stage: resolves source operands with EX/MEM/WB forwarding, stalls on
// hazards it cannot forward, and holds the ID/EX pipeline register.
module id_operand_stage #(
  parameter int CTRL_W = 16,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [4:0]        in_rs1_addr,
  input  logic [4:0]        in_rs2_addr,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [4:0]        in_rd_addr,
  input  logic              in_rd_we,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_rs1_addr,
  output logic [4:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_dout,
  input  logic [XLEN-1:0]   rf_rs2_dout,
  input  logic              ex_we,
  input  logic [4:0]        ex_rd_addr,
  input  logic              ex_data_ok,
  input  logic [XLEN-1:0]   ex_data,
  input  logic              mem_we,
  input  logic [4:0]        mem_rd_addr,
  input  logic [XLEN-1:0]   mem_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd_addr,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic [4:0] rs1_q, rs2_q;
  logic use1_q, use2_q;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd, rs1_hold, rs2_hold;
  logic haz1, haz2, hazard;
  assign rf_rs1_addr = in_rs1_addr;
  assign rf_rs2_addr = in_rs2_addr;
  always_comb begin
    rs1_fwd = (in_rs1_addr == 5'd0) ? '0 :
              (ex_we && ex_rd_addr == in_rs1_addr) ? ex_data :
              (mem_we && mem_rd_addr == in_rs1_addr) ? mem_data :
              (wb_we && wb_rd_addr == in_rs1_addr) ? wb_data : rf_rs1_dout;
    rs2_fwd = (in_rs2_addr == 5'd0) ? '0 :
              (ex_we && ex_rd_addr == in_rs2_addr) ? ex_data :
              (mem_we && mem_rd_addr == in_rs2_addr) ? mem_data :
              (wb_we && wb_rd_addr == in_rs2_addr) ? wb_data : rf_rs2_dout;
    // A held instruction cannot see EX: that result belongs to an older, already-resolved producer
    rs1_hold = (!use1_q || rs1_q == 5'd0) ? out_rs1_val :
               (mem_we && mem_rd_addr == rs1_q) ? mem_data :
               (wb_we && wb_rd_addr == rs1_q) ? wb_data : out_rs1_val;
    rs2_hold = (!use2_q || rs2_q == 5'd0) ? out_rs2_val :
               (mem_we && mem_rd_addr == rs2_q) ? mem_data :
               (wb_we && wb_rd_addr == rs2_q) ? wb_data : out_rs2_val;
    haz1 = in_use_rs1 && in_rs1_addr != 5'd0 &&
           ((out_valid && out_rd_we && out_rd_addr == in_rs1_addr) ||
            (ex_we && ex_rd_addr == in_rs1_addr && !ex_data_ok));
    haz2 = in_use_rs2 && in_rs2_addr != 5'd0 &&
           ((out_valid && out_rd_we && out_rd_addr == in_rs2_addr) ||
            (ex_we && ex_rd_addr == in_rs2_addr && !ex_data_ok));
    hazard = in_valid && (haz1 || haz2);
    in_ready = !flush && !hazard && (!out_valid || out_ready);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm <= '0;
      out_rd_addr <= '0;
      out_rd_we <= 1'b0;
      out_ctrl <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      use1_q <= 1'b0;
      use2_q <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_rs1_val <= rs1_fwd;
      out_rs2_val <= rs2_fwd;
      out_imm <= in_imm;
      out_rd_addr <= in_rd_addr;
      out_rd_we <= in_rd_we;
      out_ctrl <= in_ctrl;
      rs1_q <= in_rs1_addr;
      rs2_q <= in_rs2_addr;
      use1_q <= in_use_rs1;
      use2_q <= in_use_rs2;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      out_rs1_val <= rs1_hold;
      out_rs2_val <= rs2_hold;
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed stimulus checked every cycle against a behavioural
// model of the operand stage, plus hand-computed literal expectations.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic rstn;
  logic in_valid, in_ready, in_use_rs1, in_use_rs2, in_rd_we;
  logic [31:0] in_pc, in_imm, rf_rs1_dout, rf_rs2_dout, ex_data, mem_data, wb_data;
  logic [4:0] in_rs1_addr, in_rs2_addr, in_rd_addr, rf_rs1_addr, rf_rs2_addr;
  logic [15:0] in_ctrl, out_ctrl;
  logic ex_we, ex_data_ok, mem_we, wb_we, flush, out_valid, out_ready, out_rd_we;
  logic [4:0] ex_rd_addr, mem_rd_addr, wb_rd_addr, out_rd_addr;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  int checks = 0, errors = 0;
  logic m_valid, m_we, m_u1, m_u2;
  logic [31:0] m_pc, m_r1, m_r2, m_imm;
  logic [4:0] m_rd, m_a1, m_a2;
  logic [15:0] m_ctrl;

  id_operand_stage #(.CTRL_W(16), .XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_use_rs1(in_use_rs1),
    .in_use_rs2(in_use_rs2), .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .in_imm(in_imm),
    .in_ctrl(in_ctrl), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout), .ex_we(ex_we),
    .ex_rd_addr(ex_rd_addr), .ex_data_ok(ex_data_ok), .ex_data(ex_data), .mem_we(mem_we),
    .mem_rd_addr(mem_rd_addr), .mem_data(mem_data), .wb_we(wb_we), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Producers listed youngest first; the first one naming the register supplies it
  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf, input logic with_ex);
    logic we[3];
    logic [4:0] rd[3];
    logic [31:0] d[3];
    we = '{with_ex && ex_we, mem_we, wb_we};
    rd = '{ex_rd_addr, mem_rd_addr, wb_rd_addr};
    d = '{ex_data, mem_data, wb_data};
    if (a == 5'd0) return 32'h0;
    for (int i = 0; i < 3; i++)
      if (we[i] && rd[i] == a) return d[i];
    return rf;
  endfunction

  function automatic logic blocked(input logic [4:0] a, input logic u);
    return u && a != 5'd0 && ((m_valid && m_we && m_rd == a) || (ex_we && ex_rd_addr == a && !ex_data_ok));
  endfunction

  function automatic logic exp_ready();
    return !flush && !(in_valid && (blocked(in_rs1_addr, in_use_rs1) || blocked(in_rs2_addr, in_use_rs2)))
           && (!m_valid || out_ready);
  endfunction

  task automatic mreset();
    m_valid = 0; m_we = 0; m_u1 = 0; m_u2 = 0; m_pc = 0; m_r1 = 0; m_r2 = 0;
    m_imm = 0; m_rd = 0; m_a1 = 0; m_a2 = 0; m_ctrl = 0;
  endtask

  task automatic model_edge();
    logic take;
    take = in_valid && exp_ready();
    if (flush) m_valid = 0;
    else if (take) begin
      m_valid = 1; m_pc = in_pc; m_imm = in_imm; m_ctrl = in_ctrl; m_rd = in_rd_addr; m_we = in_rd_we;
      m_a1 = in_rs1_addr; m_a2 = in_rs2_addr; m_u1 = in_use_rs1; m_u2 = in_use_rs2;
      m_r1 = resolve(in_rs1_addr, rf_rs1_dout, 1'b1);
      m_r2 = resolve(in_rs2_addr, rf_rs2_dout, 1'b1);
    end else if (m_valid && out_ready) m_valid = 0;
    else if (m_valid) begin
      if (m_u1) m_r1 = resolve(m_a1, m_r1, 1'b0);
      if (m_u2) m_r2 = resolve(m_a2, m_r2, 1'b0);
    end
  endtask

  task automatic cycle();
    #1;
    chk("in_ready", in_ready, exp_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_pc", out_pc, m_pc);
      chk("out_rs1_val", out_rs1_val, m_r1);
      chk("out_rs2_val", out_rs2_val, m_r2);
      chk("out_imm", out_imm, m_imm);
      chk("out_rd_ctrl", {10'd0, out_rd_addr, out_rd_we, out_ctrl}, {10'd0, m_rd, m_we, m_ctrl});
    end
  endtask

  task automatic idle();
    in_valid = 0; in_pc = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd_addr = 0; in_rd_we = 0; in_imm = 0; in_ctrl = 0; rf_rs1_dout = 0; rf_rs2_dout = 0;
    ex_we = 0; ex_rd_addr = 0; ex_data_ok = 1; ex_data = 0; mem_we = 0; mem_rd_addr = 0;
    mem_data = 0; wb_we = 0; wb_rd_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                       input logic u1, input logic u2, input logic [4:0] rd, input logic we,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1; in_pc = pc; in_rs1_addr = a1; in_rs2_addr = a2; in_use_rs1 = u1; in_use_rs2 = u2;
    in_rd_addr = rd; in_rd_we = we; in_imm = ~pc; in_ctrl = pc[15:0] ^ 16'hA5A5;
    rf_rs1_dout = r1; rf_rs2_dout = r2;
  endtask

  initial begin
    idle();
    mreset();
    rstn = 0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_pc", out_pc, 0);
    chk("rst_rs1", out_rs1_val, 0);
    @(negedge clk);
    rstn = 1;
    issue(32'h100, 5, 6, 1, 1, 0, 0, 32'h1234, 32'h0);
    cycle();
    chk("basic_rs1", out_rs1_val, 32'h1234);
    issue(32'h104, 5, 0, 1, 0, 0, 0, 32'hD, 32'h0);
    ex_we = 1; ex_rd_addr = 5; ex_data = 32'hA; ex_data_ok = 1;
    mem_we = 1; mem_rd_addr = 5; mem_data = 32'hB;
    wb_we = 1; wb_rd_addr = 5; wb_data = 32'hC;
    cycle();
    chk("fwd_ex", out_rs1_val, 32'hA);
    ex_we = 0; in_pc = 32'h108;
    cycle();
    chk("fwd_mem", out_rs1_val, 32'hB);
    mem_we = 0; in_pc = 32'h10C;
    cycle();
    chk("fwd_wb", out_rs1_val, 32'hC);
    ex_we = 1; mem_we = 1; wb_we = 1; ex_rd_addr = 0; mem_rd_addr = 0; wb_rd_addr = 0;
    ex_data = 32'hFFFFFFFF; mem_data = 32'hFFFFFFFF; wb_data = 32'hFFFFFFFF;
    in_rs1_addr = 0; rf_rs1_dout = 32'hFFFFFFFF; in_pc = 32'h110;
    cycle();
    chk("fwd_x0", out_rs1_val, 32'h0);
    idle();
    issue(32'h200, 1, 2, 1, 1, 7, 1, 32'h1, 32'h2);
    cycle();
    issue(32'h204, 7, 0, 1, 0, 8, 1, 32'hDEAD, 32'h0);
    #1 chk("haz_ready", in_ready, 0);
    cycle();
    chk("haz_bubble", out_valid, 0);
    ex_we = 1; ex_rd_addr = 7; ex_data_ok = 1; ex_data = 32'h55;
    cycle();
    chk("haz_fwd", out_rs1_val, 32'h55);
    idle();
    cycle();
    issue(32'h300, 0, 9, 0, 1, 10, 0, 32'h0, 32'h5);
    ex_we = 1; ex_rd_addr = 9; ex_data_ok = 0; ex_data = 32'h99;
    #1 chk("load_ready", in_ready, 0);
    cycle();
    cycle();
    chk("load_stall", out_valid, 0);
    ex_data_ok = 1;
    cycle();
    chk("load_fwd", out_rs2_val, 32'h99);
    ex_data_ok = 0; in_use_rs2 = 0; in_pc = 32'h304;
    #1 chk("nouse_ready", in_ready, 1);
    cycle();
    chk("nouse_rs2", out_rs2_val, 32'h99);
    idle();
    cycle();
    issue(32'h400, 1, 3, 1, 1, 4, 1, 32'h11, 32'h22);
    out_ready = 0;
    cycle();
    chk("hold_cap", out_rs2_val, 32'h22);
    in_valid = 0;
    cycle();
    wb_we = 1; wb_rd_addr = 3; wb_data = 32'h77;
    ex_we = 1; ex_rd_addr = 3; ex_data = 32'hEE; ex_data_ok = 1;
    cycle();
    wb_we = 0; ex_we = 0;
    cycle();
    chk("hold_pc", out_pc, 32'h400);
    chk("hold_rs1", out_rs1_val, 32'h11);
    chk("hold_rs2", out_rs2_val, 32'h77);
    flush = 1;
    issue(32'h500, 1, 2, 1, 1, 5, 1, 32'h1, 32'h2);
    cycle();
    chk("flush_valid", out_valid, 0);
    flush = 0;
    issue(32'h600, 1, 2, 1, 1, 6, 1, 32'h61, 32'h62);
    out_ready = 0;
    cycle();
    in_valid = 0;
    cycle();
    chk("hold_valid", out_valid, 1);
    rstn = 0;
    mreset();
    #1 chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_ready", in_ready, 1);
    #1 rstn = 1;
    #1 chk("rst_rel_ready", in_ready, 1);
    @(negedge clk);
    issue(32'h700, 4, 0, 1, 0, 0, 0, 32'h7777, 32'h0);
    out_ready = 1;
    cycle();
    chk("post_rst_rs1", out_rs1_val, 32'h7777);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode-to-execute operand stage. Drives the register_file read addresses combinationally and forwards results from EX, MEM and WB on top of the file's read data.
- Registers the resolved operands plus instruction fields into the ID/EX pipeline register.
- Detects read-after-write hazards it cannot forward, then stalls and inserts bubbles.
- Uses a valid/ready handshake toward both decode and execute.

Parameters:
CTRL_W, 16, width of opaque control bundle passed through to execute
XLEN, 32, data width; only 32 is supported

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset, asynchronous, active-low
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_pc  in  XLEN  instruction address
in_rs1_addr  in  5  source 1 index
in_rs2_addr  in  5  source 2 index
in_use_rs1  in  1  instruction reads rs1
in_use_rs2  in  1  instruction reads rs2
in_rd_addr  in  5  destination index
in_rd_we  in  1  instruction writes rd
in_imm  in  XLEN  decoded immediate
in_ctrl  in  CTRL_W  control bundle
rf_rs1_addr  out  5  register_file read address 1, equals in_rs1_addr
rf_rs2_addr  out  5  register_file read address 2, equals in_rs2_addr
rf_rs1_dout  in  XLEN  register_file read data 1
rf_rs2_dout  in  XLEN  register_file read data 2
ex_we, ex_rd_addr, ex_data_ok, ex_data  in  1/5/1/XLEN  EX-stage producer; ex_data_ok=0 means result not yet known (load)
mem_we, mem_rd_addr, mem_data  in  1/5/XLEN  MEM-stage producer
wb_we, wb_rd_addr, wb_data  in  1/5/XLEN  WB producer (same as register_file write port)
flush  in  1  kill the instruction held in the stage
out_valid  out  1  ID/EX register holds a live instruction
out_ready  in  1  execute consumes this cycle
out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  registered fields
out_rd_addr, out_rd_we, out_ctrl  out  5/1/CTRL_W  registered fields

Behaviour:
- Reset, asynchronous, while rstn=0:
  - out_valid=0.
  - All out_* data fields are 0.
  - in_ready follows its equation; with out_valid=0 and flush=0 it is 1.
  - Reset asserted mid-transfer drops the held instruction immediately.
- register_file contract:
  - Combinational read.
  - Write on the rising clk edge, enabled by wb_we.
  - wb forwarding covers the same-cycle write.
- Operand resolution, per source, first match wins:
  - Address 0: value 0, regardless of any producer.
  - ex_we && ex_rd_addr==addr: ex_data.
  - mem_we && mem_rd_addr==addr: mem_data.
  - wb_we && wb_rd_addr==addr: wb_data.
  - Otherwise rf_*_dout.
- Hazard: asserted when in_valid and either rule below holds for a used source with addr≠0.
  - Own-stage rule: out_valid && out_rd_we && out_rd_addr==addr. The producer is still in the ID/EX register, so its result does not exist yet.
  - EX-load rule: ex_we && ex_rd_addr==addr && !ex_data_ok.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Rising clk edge actions:
  - flush: out_valid<=0. This overrides everything else.
  - Otherwise, in_valid && in_ready: capture all fields with resolved operands; out_valid<=1. Latency is 1 cycle.
  - Otherwise, out_valid && out_ready: out_valid<=0. This is the bubble inserted on a hazard.
  - Otherwise, out_valid && !out_ready (hold): the pc/imm/ctrl/rd fields stay stable. out_rs1_val and out_rs2_val refresh from the mem/wb producers only, in that priority, when the address matches and is nonzero and the source is used. The ex producer is ignored during hold.
- out_* data fields when out_valid=0 are don't-care. The bench checks them only when out_valid=1.
- An unused source (use=0) never causes a hazard; its value is captured anyway.
- Simultaneous hazard and out_ready: the current instruction leaves and a bubble follows. The consumer is re-evaluated next cycle.

Test Plan:
- Reset with rstn=0 mid-hold with out_valid=1 -> out_valid=0 immediately; after release, in_ready=1.
- rs1=5, rf_rs1_dout=0x00001234, no producers, in_valid=1 -> next cycle out_valid=1, out_rs1_val=0x00001234.
- rs1=5 with ex=0xA, mem=0xB, wb=0xC, rf=0xD -> 0x0000000A. Drop ex -> 0xB. Drop mem -> 0xC. rs1=0 with all producers writing x0=0xFFFFFFFF -> 0.
- Producer rd=7 in ID/EX, consumer rs1=7, out_ready=1 -> in_ready=0, then a bubble (out_valid=0). Next cycle ex_we=1, rd=7, ex_data_ok=1, ex_data=0x55 -> consumer accepted, out_rs1_val=0x55.
- EX load on rd=9 with ex_data_ok=0 and consumer rs2=9 -> stall until ex_data_ok=1. With in_use_rs2=0 -> no stall.
- out_ready=0 for 3 cycles -> all fields stable, except a wb write to the held rs2 (0x77) updates out_rs2_val to 0x77. flush=1 together with in_valid=1 -> out_valid=0 and nothing is captured.
